pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//  Parametrised inter-stage pipeline register (ID/EX, EX/MEM, ...) with valid/ready handshake and 2-entry skid buffer.
//  Replaces ad-hoc stall latching: a downstream stall never drops or duplicates an instruction.
//  in_ready is registered, so there is no combinational path out_ready -> in_ready.
//  When empty, it inserts a bubble with a configurable "safe" control word. Also provides synchronous flush and a stall-cycle counter.
// PARAMETERS
//  DATA_W       32     width of one operand channel
//  NUM_OPS      4      operand channels carried (op1, op2, rs2o, dmem_out ...)
//  CTRL_W       12     width of packed control word (funcsel, memwr, regwr, wbsel, func3 ...)
//  BUBBLE_CTRL  0      control word driven on out_ctrl while out_valid=0; must encode memwr=0, regwr=0
//  CNT_W        16     width of stall_cnt
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  rst        in   1                 synchronous, active-high reset
//  flush      in   1                 sync kill of all held entries (branch/jump redirect)
//  in_valid   in   1                 upstream stage presents an instruction
//  in_ready   out  1                 registered; 1 = an entry can be accepted this cycle
//  in_ctrl    in   CTRL_W            upstream control word
//  in_ops     in   NUM_OPS*DATA_W    upstream operands; channel k = [k*DATA_W +: DATA_W]
//  out_valid  out  1                 main entry holds a live instruction
//  out_ready  in   1                 downstream accepts; 0 = stall
//  out_ctrl   out  CTRL_W            main entry control, or BUBBLE_CTRL when out_valid=0
//  out_ops    out  NUM_OPS*DATA_W    main entry operands, or all-zero when out_valid=0
//  stall_cnt  out  CNT_W             saturating count of cycles with out_valid & !out_ready
// BEHAVIOUR
//  Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  State is EMPTY/ONE/FULL (main entry, skid entry). in_ready = (state != FULL). out_valid = (state != EMPTY).
//  Transitions, evaluated in priority order:
//   rst                                    -> EMPTY, stall_cnt=0
//   flush                                  -> EMPTY; any in_fire in the same cycle is dropped; stall_cnt unchanged
//   EMPTY: in_fire                         -> main<=in, ONE
//   ONE:   in_fire & out_fire              -> main<=in, stay ONE
//   ONE:   in_fire & !out_fire             -> skid<=in, FULL
//   ONE:   !in_fire & out_fire             -> EMPTY
//   FULL:  out_fire                        -> main<=skid, ONE; a new input cannot enter this cycle because in_ready=0
//   all other cases                        -> hold; payload registers do not change
//  Latency is 1 cycle from in_fire to out_valid when not stalled. Throughput is 1/cycle. Strict FIFO order.
//  Reset values: out_valid=0, in_ready=1, out_ctrl=BUBBLE_CTRL, out_ops=0, stall_cnt=0.
//   Payload registers are don't-care after reset and are masked by the output mux.
//  Bubble mux: out_ctrl and out_ops are forced to BUBBLE_CTRL/0 whenever out_valid=0, including the cycle after flush.
//  stall_cnt: +1 when out_valid & !out_ready; holds at 2^CNT_W-1 (no wrap).
//  in_valid while FULL is ignored; upstream must hold its payload until in_fire.
//  rst or flush asserted mid-stall discards both entries; the next accepted input appears on the following cycle.
// STRUCTURE
//  State encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2 and the BUBBLE_CTRL field layout live in shared pipe_defs.vh,
//   so all stage registers and hazard units agree on them.
//  Single module, no sub-module: main/skid payload regs, 2-bit state reg, output mux, counter.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> out_valid=0, in_ready=1, out_ctrl=BUBBLE_CTRL, stall_cnt=0.
//  2 Stream: in_valid=1 with ops 0x1,0x2,0x3, out_ready=1 -> out_ops 0x1,0x2,0x3 on consecutive cycles, 1-cycle latency.
//  3 Stall skid: present A then B, drop out_ready after A's in_fire for 3 cycles ->
//     FULL, in_ready=0, out holds A, stall_cnt=3; on release out A then B, nothing lost or duplicated.
//  4 Flush in FULL with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL; C never appears at the output.
//  5 Saturation: CNT_W=4, out_ready=0 for 20 cycles with a live entry -> stall_cnt stops at 15.
//  6 Random valid/ready with a scoreboard over 10k cycles -> order preserved, in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for pipeline stage registers: occupancy encoding,
// control-word layout and the default safe bubble.
package pipe_stage_skid_reg_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_NUM_OPS = 4;
  localparam int unsigned DEF_CTRL_W  = 12;
  localparam int unsigned DEF_CNT_W   = 16;

  // Occupancy of a stage register: no entry, main entry only, main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Control-word field layout shared by all stages and hazard units.
  typedef struct packed {
    logic [3:0] funcsel;
    logic       memwr;
    logic       regwr;
    logic [1:0] wbsel;
    logic [2:0] func3;
    logic       spare;
  } ctrl_word_t;

  // A bubble must never write memory or the register file.
  localparam ctrl_word_t SAFE_BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready handshake bundle carrying one instruction between stages.
interface pipe_stage_skid_reg_if
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int unsigned CTRL_W  = DEF_CTRL_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned NUM_OPS = DEF_NUM_OPS
);

  localparam int unsigned OPS_W = NUM_OPS * DATA_W;

  logic               valid;
  logic               ready;
  logic [CTRL_W-1:0]  ctrl;
  logic [OPS_W-1:0]   ops;

  // Producer side drives the payload, consumer side drives ready.
  modport master (output valid, output ctrl, output ops, input  ready);
  modport slave  (input  valid, input  ctrl, input  ops, output ready);

endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer, registered
// in_ready, bubble insertion, synchronous flush and a saturating stall counter.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       NUM_OPS     = DEF_NUM_OPS,
  parameter int unsigned       CTRL_W      = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(SAFE_BUBBLE_CTRL),
  parameter int unsigned       CNT_W       = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  pipe_stage_skid_reg_if.slave  in_if,
  pipe_stage_skid_reg_if.master out_if,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int unsigned      OPS_W   = NUM_OPS * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_state_e      state_q,     state_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [OPS_W-1:0]  main_ops_q,  main_ops_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [OPS_W-1:0]  skid_ops_q,  skid_ops_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_fire;
  logic              out_fire;

  // Main entry doubles as the output register; it is loaded with the bubble
  // whenever the stage empties, so no output mux is needed.
  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid_q;
  assign out_if.ctrl  = main_ctrl_q;
  assign out_if.ops   = main_ops_q;
  assign stall_cnt_o  = stall_cnt_q;

  // Next-state: occupancy transitions, payload moves and stall counting.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_ops_d  = main_ops_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_ops_d  = skid_ops_q;
    stall_cnt_d = stall_cnt_q;
    in_fire     = in_if.valid & in_ready_q;
    out_fire    = out_valid_q & out_if.ready;

    if (flush_i) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = BUBBLE_CTRL;
      main_ops_d  = '0;
    end else begin
      if (out_valid_q && !out_if.ready && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = in_if.ctrl;
            main_ops_d  = in_if.ops;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_if.ctrl;
            main_ops_d  = in_if.ops;
          end else if (in_fire) begin
            skid_ctrl_d = in_if.ctrl;
            skid_ops_d  = in_if.ops;
            state_d     = ST_FULL;
          end else if (out_fire) begin
            main_ctrl_d = BUBBLE_CTRL;
            main_ops_d  = '0;
            state_d     = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_ops_d  = skid_ops_q;
            state_d     = ST_ONE;
          end
        end
        default: begin
          main_ctrl_d = BUBBLE_CTRL;
          main_ops_d  = '0;
          state_d     = ST_EMPTY;
        end
      endcase
    end

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State, payload and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= BUBBLE_CTRL;
      main_ops_q  <= '0;
      skid_ctrl_q <= BUBBLE_CTRL;
      skid_ops_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_ctrl_q <= main_ctrl_d;
      main_ops_q  <= main_ops_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_ops_q  <= skid_ops_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus a randomized run
// against a FIFO-of-two reference model.
module tb_pipe_stage_skid_reg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_OPS = 4;
  localparam int unsigned CTRL_W  = 12;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OPS_W   = DATA_W * NUM_OPS;
  localparam int unsigned OUT_W   = 2 + CTRL_W + OPS_W + CNT_W;
  localparam logic [CTRL_W-1:0] BUBBLE = 12'hA0A;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an in-order queue of at most two instructions.
  logic [CTRL_W-1:0] mq_ctrl[$];
  logic [OPS_W-1:0]  mq_ops[$];
  int                m_cnt = 0;
  int                n_out = 0;

  pipe_stage_skid_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS)) up_if ();
  pipe_stage_skid_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS)) dn_if ();

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .CTRL_W(CTRL_W),
    .BUBBLE_CTRL(BUBBLE), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_if(up_if), .out_if(dn_if), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] pack(input logic v, input logic r,
                                            input logic [CTRL_W-1:0] c,
                                            input logic [OPS_W-1:0] o, input int n);
    return {v, r, c, o, CNT_W'(n)};
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    if (mq_ctrl.size() == 0) return pack(1'b0, 1'b1, BUBBLE, '0, m_cnt);
    return pack(1'b1, mq_ctrl.size() < 2, mq_ctrl[0], mq_ops[0], m_cnt);
  endfunction

  function automatic logic [OUT_W-1:0] obs();
    return {dn_if.valid, up_if.ready, dn_if.ctrl, dn_if.ops, stall_cnt};
  endfunction

  function automatic logic [OPS_W-1:0] rand_ops();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [OPS_W-1:0] o);
    up_if.valid = v;
    up_if.ctrl  = c;
    up_if.ops   = o;
  endtask

  // Advance the model by one clock from the currently driven inputs, then
  // move to the next falling edge where outputs are sampled.
  task automatic tick();
    bit inf, outf;
    inf  = up_if.valid && (mq_ctrl.size() < 2);
    outf = (mq_ctrl.size() > 0) && dn_if.ready;
    if (rst) begin
      mq_ctrl.delete(); mq_ops.delete(); m_cnt = 0;
    end else if (flush) begin
      mq_ctrl.delete(); mq_ops.delete();
    end else begin
      if (mq_ctrl.size() > 0 && !dn_if.ready && m_cnt < CNT_SAT) m_cnt++;
      if (outf) begin
        void'(mq_ctrl.pop_front()); void'(mq_ops.pop_front()); n_out++;
      end
      if (inf) begin
        mq_ctrl.push_back(up_if.ctrl); mq_ops.push_back(up_if.ops);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; dn_if.ready = 1'b0;
    drive(1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs() !== pack(1'b0, 1'b1, BUBBLE, '0, 0))
        $display("FAIL reset_%0d: got %h want %h", i, obs(), pack(1'b0, 1'b1, BUBBLE, '0, 0));
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      logic [OUT_W-1:0] exp;
      if (i == 1) exp = pack(1'b0, 1'b1, BUBBLE, '0, 0);
      else        exp = pack(1'b1, 1'b1, CTRL_W'(12'h100 + i - 1), OPS_W'(i - 1), 0);
      if (i <= 3) drive(1'b1, CTRL_W'(12'h100 + i), OPS_W'(i));
      else        drive(1'b0, '0, '0);
      n_checks++;
      if (obs() !== exp) $display("FAIL stream_%0d: got %h want %h", i, obs(), exp);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (obs() !== pack(1'b0, 1'b1, BUBBLE, '0, 0))
      $display("FAIL stream_drain: got %h want %h", obs(), pack(1'b0, 1'b1, BUBBLE, '0, 0));
    else n_pass++;
  endtask

  task automatic test_stall_skid();
    logic [CTRL_W-1:0] ca = 12'h3C1, cb = 12'h2B2;
    logic [OPS_W-1:0]  oa = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    logic [OPS_W-1:0]  ob = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    logic [OUT_W-1:0]  exp;
    dn_if.ready = 1'b1;
    drive(1'b1, ca, oa);
    tick();
    n_checks++;
    if (obs() !== pack(1'b1, 1'b1, ca, oa, 0))
      $display("FAIL stall_a_out: got %h want %h", obs(), pack(1'b1, 1'b1, ca, oa, 0));
    else n_pass++;
    drive(1'b1, cb, ob);
    dn_if.ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      drive(1'b0, '0, '0);
      exp = pack(1'b1, 1'b0, ca, oa, i);
      n_checks++;
      if (obs() !== exp) $display("FAIL stall_full_%0d: got %h want %h", i, obs(), exp);
      else n_pass++;
    end
    dn_if.ready = 1'b1;
    tick();
    n_checks++;
    if (obs() !== pack(1'b1, 1'b1, cb, ob, 3))
      $display("FAIL stall_release_b: got %h want %h", obs(), pack(1'b1, 1'b1, cb, ob, 3));
    else n_pass++;
    tick();
    n_checks++;
    if (obs() !== pack(1'b0, 1'b1, BUBBLE, '0, 3))
      $display("FAIL stall_drain: got %h want %h", obs(), pack(1'b0, 1'b1, BUBBLE, '0, 3));
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [OPS_W-1:0] od = rand_ops(), oe = rand_ops(), oc = rand_ops();
    logic [OPS_W-1:0] of = rand_ops(), og = rand_ops(), oh = rand_ops();
    dn_if.ready = 1'b0;
    drive(1'b1, 12'h0D1, od); tick();
    drive(1'b1, 12'h0E2, oe); tick();
    n_checks++;
    if (obs() !== pack(1'b1, 1'b0, 12'h0D1, od, 4))
      $display("FAIL flush_setup_full: got %h want %h", obs(), pack(1'b1, 1'b0, 12'h0D1, od, 4));
    else n_pass++;
    drive(1'b1, 12'h0C3, oc); flush = 1'b1; tick(); flush = 1'b0;
    n_checks++;
    if (obs() !== pack(1'b0, 1'b1, BUBBLE, '0, 4))
      $display("FAIL flush_full_bubble: got %h want %h", obs(), pack(1'b0, 1'b1, BUBBLE, '0, 4));
    else n_pass++;
    drive(1'b0, '0, '0); dn_if.ready = 1'b1; tick();
    n_checks++;
    if (obs() !== pack(1'b0, 1'b1, BUBBLE, '0, 4))
      $display("FAIL flush_c_gone: got %h want %h", obs(), pack(1'b0, 1'b1, BUBBLE, '0, 4));
    else n_pass++;
    dn_if.ready = 1'b0;
    drive(1'b1, 12'h0F4, of); tick();
    drive(1'b1, 12'h065, og); flush = 1'b1; tick(); flush = 1'b0;
    n_checks++;
    if (obs() !== pack(1'b0, 1'b1, BUBBLE, '0, 4))
      $display("FAIL flush_one_drop: got %h want %h", obs(), pack(1'b0, 1'b1, BUBBLE, '0, 4));
    else n_pass++;
    drive(1'b1, 12'h076, oh); dn_if.ready = 1'b1; tick();
    n_checks++;
    if (obs() !== pack(1'b1, 1'b1, 12'h076, oh, 4))
      $display("FAIL flush_next_accept: got %h want %h", obs(), pack(1'b1, 1'b1, 12'h076, oh, 4));
    else n_pass++;
    drive(1'b0, '0, '0); tick();
  endtask

  task automatic test_saturation();
    logic [OPS_W-1:0] os = rand_ops();
    int base;
    int exp_n;
    dn_if.ready = 1'b0;
    drive(1'b1, 12'h5A7, os); tick();
    drive(1'b0, '0, '0);
    base = 4;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_n = (base + i > CNT_SAT) ? CNT_SAT : base + i;
      n_checks++;
      if (obs() !== pack(1'b1, 1'b1, 12'h5A7, os, exp_n))
        $display("FAIL sat_%0d: got %h want %h", i, obs(), pack(1'b1, 1'b1, 12'h5A7, os, exp_n));
      else n_pass++;
    end
    n_checks++;
    if (stall_cnt !== 4'd15) $display("FAIL sat_final: got %0d want 15", stall_cnt);
    else n_pass++;
    dn_if.ready = 1'b1; tick();
  endtask

  task automatic test_random();
    bit hold = 1'b0;
    int pr;
    logic r0;
    for (int i = 0; i < 10000; i++) begin
      pr    = ((i / 500) % 2 == 1) ? 30 : 85;
      rst   = ($urandom_range(0, 399) == 0);
      flush = ($urandom_range(0, 39) == 0);
      dn_if.ready = ($urandom_range(0, 99) < pr);
      if (!hold) begin
        if ($urandom_range(0, 99) < 70) drive(1'b1, CTRL_W'($urandom), rand_ops());
        else                             drive(1'b0, '0, '0);
      end
      n_checks++;
      if (obs() !== model_out())
        $display("FAIL rand_%0d: got %h want %h", i, obs(), model_out());
      else n_pass++;
      r0 = up_if.ready;
      dn_if.ready = ~dn_if.ready;
      #1;
      n_checks++;
      if (up_if.ready !== r0)
        $display("FAIL rand_ready_comb_%0d: got %b want %b", i, up_if.ready, r0);
      else n_pass++;
      dn_if.ready = ~dn_if.ready;
      #1;
      hold = up_if.valid && (mq_ctrl.size() >= 2) && !rst && !flush;
      tick();
    end
    rst = 1'b0; flush = 1'b0;
    n_checks++;
    if (n_out <= 1000) $display("FAIL rand_progress: got %0d outputs want >1000", n_out);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dn_if.ready = 1'b0;
    drive(1'b0, '0, '0);
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
